// File: rtl/mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
// Multicycle control FSM for a shared MIPS-subset datapath (PC, unified memory,
// IR, register bank, A/B, ALUOut, EPC, ula32 ALU). Each state drives one cycle
// of mux selects and load enables. Memory access states are stretched by
// MEM_WAIT extra cycles. ALU overflow and unknown opcodes/functs are routed
// through EXC, which saves PC-4 to EPC and jumps to the exception vector.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   opcode      IR[31:26]
//   funct       IR[5:0]
//   overflow    ula32 Overflow
//   zero        ula32 z
//   pc_write    PC load enable
//   pc_src      PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=exc vector
//   iord        memory address: 0=PC, 1=ALUOut
//   mem_wr      memory write strobe
//   ir_write    IR load
//   mdr_load    memory data register load
//   ab_load     A/B load
//   aluout_load ALUOut load
//   reg_write   register bank write
//   reg_dst     write register: 0=rt, 1=rd
//   mem_to_reg  write data: 0=ALUOut, 1=MDR
//   alu_src_a   ALU A: 0=PC, 1=A
//   alu_src_b   ALU B: 0=B, 1=4, 2=sign-ext imm, 3=sign-ext imm<<2
//   alu_op      ula32 Seletor: 001 add, 010 sub, 011 and
//   epc_write   EPC load
//   state       current state code (debug)
// -----------------------------------------------------------------------------
module mc_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               overflow,
  input  logic               zero,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               mem_wr,
  output logic               ir_write,
  output logic               mdr_load,
  output logic               ab_load,
  output logic               aluout_load,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               epc_write,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WB = 4'd7,
    S_MEM_WR = 4'd8,
    S_R_WB   = 4'd9,
    S_I_WB   = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_EXC    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       cnt_done;
  logic       mem_state;
  logic [2:0] fn_alu_op;
  logic       fn_valid;
  logic       fn_arith;

  assign cnt_done  = (cnt_q == WAIT_LAST);
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);

  // R-type function decode; fn_arith marks the ops whose overflow traps.
  always_comb begin
    fn_alu_op = ALU_NONE;
    fn_valid  = 1'b1;
    fn_arith  = 1'b0;
    unique case (funct)
      FN_ADD:  begin fn_alu_op = ALU_ADD; fn_arith = 1'b1; end
      FN_SUB:  begin fn_alu_op = ALU_SUB; fn_arith = 1'b1; end
      FN_AND:  fn_alu_op = ALU_AND;
      default: fn_valid  = 1'b0;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= 4'd0;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every comb output gets a default up front; a path that leaves one
    // unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = 4'd0;

    // The counter only runs while stretching a memory access and restarts
    // from zero on the way out, so each access gets the full MEM_WAIT+1.
    if (mem_state && !cnt_done) begin
      cnt_d = cnt_q + 4'd1;
    end

    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (cnt_done) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_EXC;
        endcase
      end
      S_EXEC_R: begin
        if (!fn_valid || (fn_arith && overflow)) state_d = S_EXC;
        else                                     state_d = S_R_WB;
      end
      S_EXEC_I: state_d = overflow ? S_EXC : S_I_WB;
      S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (cnt_done) state_d = S_MEM_WB;
      S_MEM_WR: if (cnt_done) state_d = S_FETCH;
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_EXC: state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
  end

  // Output decode of the registered state (plus funct/zero where needed).
  always_comb begin
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    iord        = 1'b0;
    mem_wr      = 1'b0;
    ir_write    = 1'b0;
    mdr_load    = 1'b0;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = ALU_NONE;
    epc_write   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // Loads happen only on the last cycle of the stretched access.
        if (cnt_done) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'd1;
          alu_op    = ALU_ADD;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while A/B load.
        ab_load     = 1'b1;
        aluout_load = 1'b1;
        alu_src_b   = 2'd3;
        alu_op      = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_op      = fn_alu_op;
        aluout_load = fn_valid;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mdr_load = cnt_done;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
      end
      S_EXC: begin
        // PC already advanced in FETCH; PC-4 points back at the faulting word.
        epc_write = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_SUB;
        pc_write  = 1'b1;
        pc_src    = 2'd3;
      end
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_sequencer
// Two sequencer instances (MEM_WAIT=1 and MEM_WAIT=2), each with its own input
// set. For every instruction the bench pushes the expected per-cycle output
// vector trace into a queue, then pops and compares one entry per cycle.
// -----------------------------------------------------------------------------
module tb_mc_sequencer;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_load;
    logic       ab_load;
    logic       aluout_load;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       epc_write;
  } obs_t;

  logic       clk = 1'b0;
  logic       drv_reset [2];
  logic [5:0] drv_op    [2];
  logic [5:0] drv_fn    [2];
  logic       drv_ov    [2];
  logic       drv_z     [2];
  obs_t       obs       [2];

  obs_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pc_write, iord, mem_wr, ir_write, mdr_load, ab_load;
    logic       aluout_load, reg_write, reg_dst, mem_to_reg, alu_src_a, epc_write;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    mc_sequencer #(.MEM_WAIT(g + 1), .STATE_W(4)) u_dut (
      .clk         (clk),
      .reset       (drv_reset[g]),
      .opcode      (drv_op[g]),
      .funct       (drv_fn[g]),
      .overflow    (drv_ov[g]),
      .zero        (drv_z[g]),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .iord        (iord),
      .mem_wr      (mem_wr),
      .ir_write    (ir_write),
      .mdr_load    (mdr_load),
      .ab_load     (ab_load),
      .aluout_load (aluout_load),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .epc_write   (epc_write),
      .state       (state)
    );

    assign obs[g] = {state, pc_write, pc_src, iord, mem_wr, ir_write, mdr_load,
                     ab_load, aluout_load, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, alu_op, epc_write};
  end

  task automatic check(input string tag, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
               tag, got.state, got, want.state, want);
    end
  endtask

  // ---------------- expected-trace builders ----------------
  function automatic obs_t st(input logic [3:0] s);
    obs_t o = '0;
    o.state = s;
    return o;
  endfunction

  task automatic push_fetch(input int mw);
    obs_t e;
    for (int i = 0; i < mw; i++) exp_q.push_back(st(4'd1));
    e = st(4'd1);
    e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 3'b001;
    exp_q.push_back(e);
  endtask

  task automatic push_decode();
    obs_t e = st(4'd2);
    e.ab_load = 1'b1; e.aluout_load = 1'b1; e.alu_src_b = 2'd3; e.alu_op = 3'b001;
    exp_q.push_back(e);
  endtask

  task automatic push_exec_r(input logic [2:0] op, input logic load);
    obs_t e = st(4'd3);
    e.alu_src_a = 1'b1; e.alu_op = op; e.aluout_load = load;
    exp_q.push_back(e);
  endtask

  task automatic push_imm(input logic [3:0] s);
    obs_t e = st(s);
    e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 3'b001; e.aluout_load = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_mem_rd(input int mw);
    obs_t e = st(4'd6);
    e.iord = 1'b1;
    for (int i = 0; i < mw; i++) exp_q.push_back(e);
    e.mdr_load = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_mem_wr(input int n);
    obs_t e = st(4'd8);
    e.iord = 1'b1; e.mem_wr = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_wb(input logic [3:0] s, input logic dst, input logic m2r);
    obs_t e = st(s);
    e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r;
    exp_q.push_back(e);
  endtask

  task automatic push_branch(input logic pcw);
    obs_t e = st(4'd11);
    e.alu_src_a = 1'b1; e.alu_op = 3'b010; e.pc_src = 2'd1; e.pc_write = pcw;
    exp_q.push_back(e);
  endtask

  task automatic push_jump();
    obs_t e = st(4'd12);
    e.pc_write = 1'b1; e.pc_src = 2'd2;
    exp_q.push_back(e);
  endtask

  task automatic push_exc();
    obs_t e = st(4'd13);
    e.epc_write = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 3'b010;
    e.pc_write = 1'b1; e.pc_src = 2'd3;
    exp_q.push_back(e);
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input int k, input logic [5:0] op, input logic [5:0] fn,
                        input logic ov, input logic z);
    drv_op[k] = op; drv_fn[k] = fn; drv_ov[k] = ov; drv_z[k] = z;
  endtask

  // One scoreboard entry per cycle, sampled on the falling edge.
  task automatic drain(input int k, input string name);
    obs_t e;
    int   c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("dut%0d %s cyc%0d", k, name, c), obs[k], e);
      c++;
    end
  endtask

  task automatic do_reset(input int k);
    drv_reset[k] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("dut%0d reset%0d", k, i), obs[k], st(4'd0));
    end
    drv_reset[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      drv_reset[k] = 1'b1;
      set_in(k, 6'h00, 6'h20, 1'b0, 1'b0);
    end

    // ---------------- MEM_WAIT = 1 ----------------
    do_reset(0);

    set_in(0, 6'h00, 6'h20, 1'b0, 1'b0);               // add
    push_fetch(1); push_decode(); push_exec_r(3'b001, 1'b1); push_wb(4'd9, 1'b1, 1'b0);
    drain(0, "add");

    set_in(0, 6'h00, 6'h22, 1'b1, 1'b0);               // sub, overflow
    push_fetch(1); push_decode(); push_exec_r(3'b010, 1'b1); push_exc();
    drain(0, "sub_ovf");

    set_in(0, 6'h00, 6'h24, 1'b1, 1'b0);               // and ignores overflow
    push_fetch(1); push_decode(); push_exec_r(3'b011, 1'b1); push_wb(4'd9, 1'b1, 1'b0);
    drain(0, "and_ovf");

    set_in(0, 6'h00, 6'h27, 1'b0, 1'b0);               // unknown funct
    push_fetch(1); push_decode(); push_exec_r(3'b000, 1'b0); push_exc();
    drain(0, "bad_funct");

    set_in(0, 6'h04, 6'h00, 1'b0, 1'b1);               // beq taken
    push_fetch(1); push_decode(); push_branch(1'b1);
    drain(0, "beq_z1");

    set_in(0, 6'h04, 6'h00, 1'b0, 1'b0);               // beq not taken
    push_fetch(1); push_decode(); push_branch(1'b0);
    drain(0, "beq_z0");

    set_in(0, 6'h05, 6'h00, 1'b0, 1'b1);               // bne not taken
    push_fetch(1); push_decode(); push_branch(1'b0);
    drain(0, "bne_z1");

    set_in(0, 6'h02, 6'h00, 1'b1, 1'b1);               // j
    push_fetch(1); push_decode(); push_jump();
    drain(0, "jump");

    set_in(0, 6'h08, 6'h00, 1'b1, 1'b0);               // addi, overflow
    push_fetch(1); push_decode(); push_imm(4'd4); push_exc();
    drain(0, "addi_ovf");

    set_in(0, 6'h3F, 6'h20, 1'b0, 1'b0);               // unknown opcode
    push_fetch(1); push_decode(); push_exc();
    drain(0, "bad_op");

    set_in(0, 6'h2B, 6'h00, 1'b1, 1'b0);               // sw
    push_fetch(1); push_decode(); push_imm(4'd5); push_mem_wr(2);
    drain(0, "sw");

    set_in(0, 6'h23, 6'h00, 1'b1, 1'b1);               // lw
    push_fetch(1); push_decode(); push_imm(4'd5); push_mem_rd(1); push_wb(4'd7, 1'b0, 1'b1);
    drain(0, "lw");

    // ---------------- MEM_WAIT = 2 ----------------
    do_reset(1);

    set_in(1, 6'h23, 6'h00, 1'b0, 1'b0);               // lw
    push_fetch(2); push_decode(); push_imm(4'd5); push_mem_rd(2); push_wb(4'd7, 1'b0, 1'b1);
    drain(1, "lw_w2");

    set_in(1, 6'h08, 6'h00, 1'b0, 1'b0);               // addi
    push_fetch(2); push_decode(); push_imm(4'd4); push_wb(4'd10, 1'b0, 1'b0);
    drain(1, "addi");

    set_in(1, 6'h2B, 6'h00, 1'b0, 1'b0);               // sw, reset in 2nd write cycle
    push_fetch(2); push_decode(); push_imm(4'd5); push_mem_wr(1);
    drain(1, "sw_abort");
    begin
      obs_t e = st(4'd8);
      e.iord = 1'b1; e.mem_wr = 1'b1;
      @(posedge clk);
      #2;
      check("dut1 sw_abort wr2", obs[1], e);
      drv_reset[1] = 1'b1;
      #1;
      check("dut1 sw_abort async", obs[1], st(4'd0));
      @(negedge clk);
      check("dut1 sw_abort held", obs[1], st(4'd0));
      drv_reset[1] = 1'b0;
    end

    set_in(1, 6'h00, 6'h20, 1'b0, 1'b0);               // add after abort
    push_fetch(2); push_decode(); push_exec_r(3'b001, 1'b1); push_wb(4'd9, 1'b1, 1'b0);
    drain(1, "add_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
